// File: rtl/logic_op_pkg.sv
// logic_op_pkg
// Shared types and helpers for the logic_op_acc streaming bitwise accumulator.
//   op_e      : operation selector carried on s_op (AND/OR/XOR/NAND)
//   state_e   : packet FSM states (IDLE/ACC/HOLD)
//   f_base_op : the per-bit base operation for an op. NAND uses AND as its base,
//               and the inversion is applied only once, at the output.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic f_base_op(op_e op, logic x, logic y);
    logic r;
    case (op)
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      default: r = x & y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_acc_if.sv
// logic_op_acc_if
// Bundles the operand stream (s_*) and the result stream (m_*) of logic_op_acc.
//   s_valid/s_ready : operand beat handshake
//   s_a, s_b        : operands, G_WIDTH bits
//   s_op            : op select (0=AND 1=OR 2=XOR 3=NAND), used on first beat
//   s_last          : final beat of packet
//   m_valid/m_ready : result handshake
//   m_data          : folded packet result, G_WIDTH bits
//   m_count         : beats in packet, G_CNT_W bits, saturating
// master : the side that produces operands and consumes results
// slave  : the accumulator block itself
interface logic_op_acc_if #(
  parameter int G_WIDTH = 8,
  parameter int G_CNT_W = 8
);

  logic               s_valid;
  logic               s_ready;
  logic [G_WIDTH-1:0] s_a;
  logic [G_WIDTH-1:0] s_b;
  logic [1:0]         s_op;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [G_WIDTH-1:0] m_data;
  logic [G_CNT_W-1:0] m_count;

  modport master (
    output s_valid, s_a, s_b, s_op, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count
  );

  modport slave (
    input  s_valid, s_a, s_b, s_op, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count
  );

endinterface

// File: rtl/logic_op_alu.sv
// logic_op_alu
// Combinational G_WIDTH-bit bitwise unit applying the base operation of op.
//   op : operation select (NAND behaves as AND here)
//   x  : first operand
//   y  : second operand
//   r  : result
module logic_op_alu
  import logic_op_pkg::*;
#(
  parameter int G_WIDTH = 8
) (
  input  op_e                op,
  input  logic [G_WIDTH-1:0] x,
  input  logic [G_WIDTH-1:0] y,
  output logic [G_WIDTH-1:0] r
);

  always_comb begin
    r = '0;
    for (int i = 0; i < G_WIDTH; i++) begin
      r[i] = f_base_op(op, x[i], y[i]);
    end
  end

endmodule

// File: rtl/logic_op_acc.sv
// logic_op_acc
// Streaming bitwise accumulator. Each accepted beat produces r = a BASE b.
// The per-beat values are folded across a packet delimited by s_last, and one
// result plus a saturating beat count is emitted per packet.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset. It discards any partial or pending packet.
//   bus   : logic_op_acc_if slave modport (operand stream in, result stream out)
// Parameters: G_WIDTH operand/result width, G_CNT_W beat-counter width.
module logic_op_acc
  import logic_op_pkg::*;
#(
  parameter int G_WIDTH = 8,
  parameter int G_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  logic_op_acc_if.slave  bus
);

  state_e             state;
  op_e                op_q;
  logic [G_WIDTH-1:0] acc_q;
  logic [G_CNT_W-1:0] cnt_q;

  logic               beat_fire;
  op_e                beat_op;
  logic [G_WIDTH-1:0] beat_r;
  logic [G_WIDTH-1:0] fold_r;

  assign bus.s_ready = (state != HOLD) && rst_n;
  assign bus.m_valid = (state == HOLD);
  assign bus.m_data  = (op_q == OP_NAND) ? ~acc_q : acc_q;
  assign bus.m_count = cnt_q;

  assign beat_fire = bus.s_valid && bus.s_ready;

  // The first beat of a packet takes its op straight from the bus. Later beats
  // use the latched op, so s_op changes in the middle of a packet are ignored.
  assign beat_op = (state == IDLE) ? op_e'(bus.s_op) : op_q;

  logic_op_alu #(.G_WIDTH(G_WIDTH)) u_beat_alu (
    .op (beat_op),
    .x  (bus.s_a),
    .y  (bus.s_b),
    .r  (beat_r)
  );

  logic_op_alu #(.G_WIDTH(G_WIDTH)) u_fold_alu (
    .op (op_q),
    .x  (acc_q),
    .y  (beat_r),
    .r  (fold_r)
  );

  // The result registers hold their value in HOLD, so m_data and m_count stay
  // stable under backpressure. No beat is taken in HOLD, which gives the
  // one-cycle bubble between packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_AND;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat_fire) begin
            acc_q <= beat_r;
            op_q  <= op_e'(bus.s_op);
            cnt_q <= G_CNT_W'(1);
            state <= bus.s_last ? HOLD : ACC;
          end
        end
        ACC: begin
          if (beat_fire) begin
            acc_q <= fold_r;
            // Saturate rather than wrap so long packets still report all-ones.
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + G_CNT_W'(1);
            end
            if (bus.s_last) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_acc.sv
// tb_logic_op_acc
// Drives identical operand streams into two logic_op_acc instances: one with an
// 8-bit beat counter and one with a 2-bit counter to exercise saturation. Every
// presented result is compared against a packet-level reference model.
module tb_logic_op_acc;

  logic clk;
  logic rst_n;

  logic_op_acc_if #(.G_WIDTH(8), .G_CNT_W(8)) bus8 ();
  logic_op_acc_if #(.G_WIDTH(8), .G_CNT_W(2)) bus2 ();

  logic_op_acc #(.G_WIDTH(8), .G_CNT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  logic_op_acc #(.G_WIDTH(8), .G_CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] pkt_a  [16];
  logic [7:0] pkt_b  [16];
  logic [1:0] pkt_op [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: the whole packet reduces to the op applied across every
  // operand of every beat (identity-seeded), inverted at the end for NAND.
  // The op is the one presented with the first beat.
  function automatic exp_t modelPacket(input int n);
    exp_t       e;
    logic [1:0] op;
    logic [7:0] acc;
    op  = pkt_op[0];
    acc = (op == 2'd0 || op == 2'd3) ? 8'hFF : 8'h00;
    for (int i = 0; i < n; i++) begin
      case (op)
        2'd1:    acc = acc | pkt_a[i] | pkt_b[i];
        2'd2:    acc = acc ^ pkt_a[i] ^ pkt_b[i];
        default: acc = acc & pkt_a[i] & pkt_b[i];
      endcase
    end
    e.data = (op == 2'd3) ? ~acc : acc;
    e.cnt8 = (n > 255) ? 8'd255 : 8'(n);
    e.cnt2 = (n > 3) ? 2'd3 : 2'(n);
    return e;
  endfunction

  task automatic setMReady(input logic v);
    bus8.m_ready = v;
    bus2.m_ready = v;
  endtask

  // Presents one beat to both instances, starting just after a rising edge, and
  // returns just after the edge that accepted it.
  task automatic driveBeat(input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op, input logic last);
    int guard;
    bus8.s_valid = 1'b1; bus8.s_a = a; bus8.s_b = b; bus8.s_op = op; bus8.s_last = last;
    bus2.s_valid = 1'b1; bus2.s_a = a; bus2.s_b = b; bus2.s_op = op; bus2.s_last = last;
    guard = 0;
    @(negedge clk);
    while (!bus8.s_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) checkOutput("s_ready_wait", 32'(bus8.s_ready), 32'd1);
    @(posedge clk);
    #1;
    bus8.s_valid = 1'b0; bus8.s_last = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_last = 1'b0;
  endtask

  // Sends a packet of n beats from pkt_* and checks that the result is presented
  // on the cycle after the last beat with s_ready held low (the bubble).
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      driveBeat(pkt_a[i], pkt_b[i], pkt_op[i], (i == n - 1));
    end
    exp_q.push_back(modelPacket(n));
    @(negedge clk);
    checkOutput("latency_m_valid8", 32'(bus8.m_valid), 32'd1);
    checkOutput("latency_m_valid2", 32'(bus2.m_valid), 32'd1);
    checkOutput("bubble_s_ready8", 32'(bus8.s_ready), 32'd0);
    checkOutput("bubble_s_ready2", 32'(bus2.s_ready), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_m_valid8"}, 32'(bus8.m_valid), 32'd0);
    checkOutput({tag, "_m_data8"},  32'(bus8.m_data),  32'd0);
    checkOutput({tag, "_m_count8"}, 32'(bus8.m_count), 32'd0);
    checkOutput({tag, "_s_ready8"}, 32'(bus8.s_ready), 32'd0);
    checkOutput({tag, "_m_valid2"}, 32'(bus2.m_valid), 32'd0);
    checkOutput({tag, "_m_count2"}, 32'(bus2.m_count), 32'd0);
    checkOutput({tag, "_s_ready2"}, 32'(bus2.s_ready), 32'd0);
  endtask

  // Result monitor: whenever a result is presented, it must match the oldest
  // expected packet. The entry is retired when the handshake completes.
  always @(negedge clk) begin
    if (rst_n && bus8.m_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_m_valid8", 32'd1, 32'd0);
      end else begin
        checkOutput("m_data8",  32'(bus8.m_data),  32'(exp_q[0].data));
        checkOutput("m_count8", 32'(bus8.m_count), 32'(exp_q[0].cnt8));
        checkOutput("m_valid2", 32'(bus2.m_valid), 32'd1);
        checkOutput("m_data2",  32'(bus2.m_data),  32'(exp_q[0].data));
        checkOutput("m_count2", 32'(bus2.m_count), 32'(exp_q[0].cnt2));
        if (bus8.m_ready) void'(exp_q.pop_front());
      end
    end else if (rst_n && bus2.m_valid) begin
      checkOutput("unexpected_m_valid2", 32'd1, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int hold_cycles;
    rst_n = 1'b0;
    bus8.s_valid = 1'b0; bus8.s_a = '0; bus8.s_b = '0; bus8.s_op = '0; bus8.s_last = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_a = '0; bus2.s_b = '0; bus2.s_op = '0; bus2.s_last = 1'b0;
    setMReady(1'b1);

    // Reset held for 3 cycles, then released just after a rising edge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkResetState("reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_s_ready8", 32'(bus8.s_ready), 32'd1);
    checkOutput("post_reset_s_ready2", 32'(bus2.s_ready), 32'd1);
    @(posedge clk);
    #1;

    // AND, 3 beats -> 0x20
    pkt_a[0] = 8'hF0; pkt_b[0] = 8'hFF; pkt_op[0] = 2'd0;
    pkt_a[1] = 8'h3C; pkt_b[1] = 8'hFF; pkt_op[1] = 2'd0;
    pkt_a[2] = 8'hFF; pkt_b[2] = 8'hA5; pkt_op[2] = 2'd0;
    applyStimulus(3);

    // Single-beat OR -> 0x81, then back-to-back XOR -> 0x5A
    pkt_a[0] = 8'h01; pkt_b[0] = 8'h80; pkt_op[0] = 2'd1;
    applyStimulus(1);
    pkt_a[0] = 8'hFF; pkt_b[0] = 8'h0F; pkt_op[0] = 2'd2;
    pkt_a[1] = 8'hAA; pkt_b[1] = 8'h00; pkt_op[1] = 2'd2;
    applyStimulus(2);

    // NAND with s_op switched to OR on the second beat -> 0xF3
    pkt_a[0] = 8'hFF; pkt_b[0] = 8'h0F; pkt_op[0] = 2'd3;
    pkt_a[1] = 8'hFF; pkt_b[1] = 8'h3C; pkt_op[1] = 2'd1;
    applyStimulus(2);

    // Backpressure: m_ready low for 5 cycles in HOLD
    setMReady(1'b0);
    pkt_a[0] = 8'h5A; pkt_b[0] = 8'h3C; pkt_op[0] = 2'd2;
    pkt_a[1] = 8'h11; pkt_b[1] = 8'h80; pkt_op[1] = 2'd2;
    applyStimulus(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_s_ready8", 32'(bus8.s_ready), 32'd0);
      checkOutput("bp_m_valid8", 32'(bus8.m_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    setMReady(1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_release_m_valid8", 32'(bus8.m_valid), 32'd0);
    checkOutput("bp_release_m_valid2", 32'(bus2.m_valid), 32'd0);
    @(posedge clk);
    #1;

    // 5-beat packet: 8-bit counter reads 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      pkt_a[i] = 8'(8'h10 << (i % 4)); pkt_b[i] = 8'hF7; pkt_op[i] = 2'd1;
    end
    applyStimulus(5);

    // Reset after 2 beats of a packet: no output may appear for it
    driveBeat(8'h12, 8'h34, 2'd2, 1'b0);
    driveBeat(8'h56, 8'h78, 2'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("midpkt_reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pkt_a[0] = 8'hAA; pkt_b[0] = 8'h0F; pkt_op[0] = 2'd0;
    applyStimulus(1);

    // Randomized packets with random op changes mid-packet and random backpressure
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        pkt_a[i]  = 8'($urandom);
        pkt_b[i]  = 8'($urandom);
        pkt_op[i] = 2'($urandom);
      end
      hold_cycles = $urandom_range(0, 3);
      setMReady(hold_cycles == 0);
      applyStimulus(n);
      if (hold_cycles != 0) begin
        repeat (hold_cycles) begin
          @(posedge clk);
          #1;
        end
        setMReady(1'b1);
        @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    checkOutput("final_m_valid8", 32'(bus8.m_valid), 32'd0);
    checkOutput("final_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_op_acc.md
# logic_op_acc

Parametrised, streaming successor to the combinational `and1` bitwise block. It accepts operand pairs over a valid/ready handshake and applies a selectable bitwise op (AND/OR/XOR/NAND) to each pair. Per-beat results are folded across a packet delimited by `s_last`, and one result plus a beat count is emitted per packet. It sits between an upstream operand producer and a downstream consumer, both using valid/ready.

## Interface
Parameters:
- `G_WIDTH`, 8: operand and result width in bits (≥1).
- `G_CNT_W`, 8: beat-counter width in bits (≥1).

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: block can accept a beat.
- `s_a`, in, `G_WIDTH`: operand A.
- `s_b`, in, `G_WIDTH`: operand B.
- `s_op`, in, 2: 0=AND, 1=OR, 2=XOR, 3=NAND. Sampled on the first beat of a packet only.
- `s_last`, in, 1: final beat of packet.
- `m_valid`, out, 1: result valid.
- `m_ready`, in, 1: downstream accepts result.
- `m_data`, out, `G_WIDTH`: folded packet result.
- `m_count`, out, `G_CNT_W`: beats in packet, saturating.

## Operation
- Beat accepted when `s_valid && s_ready`. Result accepted when `m_valid && m_ready`.
- Per-beat value `r = a BASE b`, where BASE is AND for AND/NAND, OR for OR, XOR for XOR.
- Accumulator, first beat: `acc = r`. Later beats: `acc = acc BASE r`.
- On output, `m_data = acc`, except NAND outputs `~acc`.
- `s_op` is latched on the first beat. Changes to `s_op` mid-packet are ignored.
- Counter: loads 1 on the first beat and increments per beat. It saturates at `2^G_CNT_W−1`; it never wraps.
- FSM states:
  - IDLE: awaiting first beat. A first beat with `s_last`=1 goes to HOLD; with `s_last`=0 goes to ACC.
  - ACC: mid-packet. Stays in ACC until a beat with `s_last`=1 is accepted, then goes to HOLD.
  - HOLD: output presented. On `m_ready`=1, goes to IDLE.
- `s_ready` = (state≠HOLD) && `rst_n`. There is no beat acceptance in HOLD, including during the cycle of the output handshake; that gives a one-cycle bubble per packet.
- `m_valid` = (state==HOLD). `m_data` and `m_count` stay stable while `m_valid && !m_ready`.
- While `rst_n`=0:
  - state is IDLE.
  - acc, count, latched op, `m_data` and `m_count` are 0.
  - `m_valid` and `s_ready` are 0.
- Reset asserted mid-packet or in HOLD discards the partial or pending result. No output is produced for it.

## Timing
- Latency: `m_valid` rises on the clock edge that accepts the `s_last` beat, so the result is visible the next cycle.
- Throughput: a packet of N beats occupies N cycles plus at least 1 cycle in HOLD.
- First beat can be accepted in the first cycle after `rst_n` deasserts.
- `s_ready` depends only on state; it does not depend combinationally on `m_ready`.
- `m_valid`, `m_data` and `m_count` are registered or decoded from state. There are no combinational paths from inputs to outputs.

## Structure
- `logic_op_pkg`: `op_e` enum (OP_AND, OP_OR, OP_XOR, OP_NAND), `state_e` enum (IDLE, ACC, HOLD), and function `f_base_op(op, x, y)`.
- One sub-module, `logic_op_alu`: a combinational `G_WIDTH` bitwise op unit (op, x, y → r). It is instantiated twice: once for the beat value and once for the fold.
- The top level holds the FSM, accumulator, latched op and saturating counter.

## Test plan
- Reset: hold `rst_n` low for 3 cycles, then release. Required: `m_valid`=0, `m_data`=0, `m_count`=0 throughout reset; `s_ready`=0 during reset and 1 on the first cycle after release.
- AND packet of 3 beats, `G_WIDTH`=8: (F0,FF), (3C,FF), (FF,A5, last). Required: `m_data`=0x20, `m_count`=3, `m_valid` the cycle after the last beat.
- Single-beat OR: (01,80, last). Required: `m_data`=0x81, `m_count`=1. Back-to-back XOR packet (FF,0F), (AA,00, last): required `m_data`=0x5A and a one-cycle bubble on `s_ready` between packets.
- NAND, 2 beats, with `s_op` driven to OR on the 2nd beat: (FF,0F), (FF,3C, last). Required: `m_data`=0xF3 (op change ignored), `m_count`=2.
- Backpressure: hold `m_ready`=0 for 5 cycles in HOLD. Required: `m_data` and `m_count` stable and `s_ready`=0 throughout; `m_valid` clears the cycle after `m_ready`=1.
- Saturation and reset: with `G_CNT_W`=2, send a 5-beat packet. Required: `m_count`=3. Then assert `rst_n` mid-packet after 2 beats. Required: no output; the next 1-beat AND packet (AA,0F, last) gives `m_data`=0x0A, `m_count`=1.
